rgbled_chain_ctrl: RTL



---
 rtl/rgbled_chain_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/rgbled_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rgbled_chain_ctrl
// Purpose  : WS281x-compatible RGB LED chain controller. Holds a per-LED
//            colour store, serialises one frame of NumLeds x 24 bits in
//            G-R-B order (MSB first) on request, inserts the latch interval
//            and can queue one further frame while busy.
// Options  : define RGBLED_BRIGHTNESS_EN to scale every channel byte by
//            (brightness_i + 1) / 256 at the LOAD cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rgbled_chain_ctrl #(
  parameter  int NumLeds     = 4,
  parameter  int T0hCycles   = 16,
  parameter  int T1hCycles   = 32,
  parameter  int BitCycles   = 50,
  parameter  int ResetCycles = 2400,
  localparam int IdxW        = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic [23:0]     wr_data_i,
  input  logic [7:0]      brightness_i,
  input  logic            go_i,
  output logic            busy_o,
  output logic            frame_done_o,
  output logic            dout_o
);

  // Timer must hold the longest single interval (latch or a bit phase).
  localparam int MaxCnt = (ResetCycles > BitCycles) ? ResetCycles : BitCycles;
  localparam int CntW   = $clog2(MaxCnt + 1);

  // Reload values: each timed phase counts down to zero inclusive.
  localparam logic [CntW-1:0] T0hLoad   = CntW'(T0hCycles - 1);
  localparam logic [CntW-1:0] T1hLoad   = CntW'(T1hCycles - 1);
  localparam logic [CntW-1:0] T0lLoad   = CntW'(BitCycles - T0hCycles - 1);
  localparam logic [CntW-1:0] T1lLoad   = CntW'(BitCycles - T1hCycles - 1);
  localparam logic [CntW-1:0] LatchLoad = CntW'(ResetCycles - 1);

  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumLeds - 1);
  localparam logic [IdxW:0]   LedCount  = (IdxW + 1)'(NumLeds);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_LATCH = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   led_idx_q, led_idx_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              dout_q, dout_d;

  logic [23:0]       store_q [NumLeds];
  logic              wr_valid;

  logic [23:0]       sel_colour;
  logic [7:0]        chan_r, chan_g, chan_b;
  logic [23:0]       load_word;

  // --------------------------------------------------------------------------
  // Colour store
  // --------------------------------------------------------------------------
  // Indices beyond the chain length can be encoded when NumLeds is not a
  // power of two; such writes are dropped.
  assign wr_valid = wr_en_i && ({1'b0, wr_idx_i} < LedCount);

  // Colour store write port; cleared by reset, writable in any state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumLeds; i++) begin
        store_q[i] <= 24'h000000;
      end
    end else if (wr_valid) begin
      store_q[wr_idx_i] <= wr_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Per-LED snapshot, optional brightness scaling and G-R-B reordering
  // --------------------------------------------------------------------------
  assign sel_colour = store_q[led_idx_q];

`ifdef RGBLED_BRIGHTNESS_EN
  // c * (b + 1) fits in 17 bits; the transmitted byte is bits [15:8].
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] br);
    logic [16:0] prod;
    prod = 17'(c) * (17'(br) + 17'd1);
    return 8'(prod >> 8);
  endfunction

  assign chan_r = scale_chan(sel_colour[23:16], brightness_i);
  assign chan_g = scale_chan(sel_colour[15:8],  brightness_i);
  assign chan_b = scale_chan(sel_colour[7:0],   brightness_i);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness_i;

  assign chan_r = sel_colour[23:16];
  assign chan_g = sel_colour[15:8];
  assign chan_b = sel_colour[7:0];
`endif

  // WS281x devices expect green first, then red, then blue.
  assign load_word = {chan_g, chan_r, chan_b};

  // --------------------------------------------------------------------------
  // Frame sequencer
  // --------------------------------------------------------------------------
  // Next-state, datapath and registered-output decode for the frame FSM.
  always_comb begin
    state_d      = state_q;
    led_idx_d    = led_idx_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Leaving IDLE consumes any queued request; staying means none exists.
        pending_d = 1'b0;
        if (go_i || pending_q) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        shift_d   = load_word;
        bit_cnt_d = 5'd23;
        cnt_d     = load_word[23] ? T1hLoad : T0hLoad;
        state_d   = ST_HIGH;
      end

      ST_HIGH: begin
        if (cnt_q == '0) begin
          cnt_d   = shift_q[23] ? T1lLoad : T0lLoad;
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_LOW: begin
        if (cnt_q == '0) begin
          if (bit_cnt_q != 5'd0) begin
            // Next bit is shift_q[22] once the register moves up by one.
            shift_d   = {shift_q[22:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 5'd1;
            cnt_d     = shift_q[22] ? T1hLoad : T0hLoad;
            state_d   = ST_HIGH;
          end else if (led_idx_q != LastIdx) begin
            led_idx_d = led_idx_q + 1'b1;
            state_d   = ST_LOAD;
          end else begin
            cnt_d   = LatchLoad;
            state_d = ST_LATCH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_LATCH: begin
        if (cnt_q == '0) begin
          frame_done_d = 1'b1;
          led_idx_d    = '0;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Requests during a frame collapse into a single queued frame.
    if ((state_q != ST_IDLE) && go_i) begin
      pending_d = 1'b1;
    end
  end

  // Outputs are decoded from next state so they line up with the state they
  // describe while still coming straight from flops.
  always_comb begin
    busy_d = (state_d != ST_IDLE) || pending_d;
    dout_d = (state_d == ST_HIGH);
  end

  // FSM, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      led_idx_q    <= '0;
      bit_cnt_q    <= 5'd0;
      shift_q      <= 24'h000000;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      dout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      led_idx_q    <= led_idx_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      dout_q       <= dout_d;
    end
  end

  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign dout_o       = dout_q;

endmodule
`default_nettype wire
